dmem_arbiter: RTL

Two-requester arbiter and sequencer for the 16-bit data memory of the multicycle RISC processor. It shares the single memory port between the CPU load/store unit (port 0) and the program/debug loader (port 1). It grants one transaction at a time, round-robin, and drives the memory's write-enable, read-enable, address and write-data. Each transaction returns a registered read result and a one-cycle acknowledge.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// The FSM state enum, the requester port indices and the default widths live here.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 256;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector.
// On a tie, the port that was not served last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// Each granted transaction runs IDLE -> ACCESS -> RESP and returns a one-cycle ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_gnt,
    output logic              rq0_ack,
    output logic              rq0_err,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_gnt,
    output logic              rq1_ack,
    output logic              rq1_err,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, nxt;
    logic              last_q;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              pick_vld;
    logic              pick_win;
    logic              in_range;
    logic [1:0]        gnt_v;
    logic [1:0]        ack_v;
    logic [1:0]        err_v;

    rr_pick2 u_pick (
        .req    ({rq1_req, rq0_req}),
        .last   (last_q),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win_q   <= pick_win;
                        we_q    <= pick_win ? rq1_we    : rq0_we;
                        addr_q  <= pick_win ? rq1_addr  : rq0_addr;
                        wdata_q <= pick_win ? rq1_wdata : rq0_wdata;
                    end
                end
                ACCESS: begin
                    // Out-of-range reads return zero rather than whatever the bus holds.
                    if (!we_q)
                        rdata_q <= in_range ? mem_rdata : '0;
                end
                RESP: last_q <= win_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt       = state;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt_v     = 2'b00;
        ack_v     = 2'b00;
        err_v     = 2'b00;
        case (state)
            IDLE: begin
                if (pick_vld)
                    nxt = ACCESS;
            end
            ACCESS: begin
                nxt          = RESP;
                gnt_v[win_q] = 1'b1;
                if (in_range) begin
                    mem_we    = we_q;
                    mem_re    = !we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
            end
            RESP: begin
                nxt          = IDLE;
                gnt_v[win_q] = 1'b1;
                ack_v[win_q] = 1'b1;
                err_v[win_q] = !in_range;
            end
            default: nxt = IDLE;
        endcase
        // Reset must suppress a write even when it lands in the middle of ACCESS.
        if (reset) begin
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            gnt_v     = 2'b00;
            ack_v     = 2'b00;
            err_v     = 2'b00;
        end
    end

    assign rq0_gnt   = gnt_v[PORT_CPU];
    assign rq1_gnt   = gnt_v[PORT_LDR];
    assign rq0_ack   = ack_v[PORT_CPU];
    assign rq1_ack   = ack_v[PORT_LDR];
    assign rq0_err   = err_v[PORT_CPU];
    assign rq1_err   = err_v[PORT_LDR];
    assign rq0_rdata = ack_v[PORT_CPU] ? rdata_q : '0;
    assign rq1_rdata = ack_v[PORT_LDR] ? rdata_q : '0;

endmodule
